// File: rtl/amiga_reset_pkg.sv
// Shared state encoding and default cycle constants for the Amiga reset controller.
// Defaults assume the 28.63636 MHz master clock.
package amiga_reset_pkg;

    typedef enum logic [1:0] {
        ST_POWERUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_KBD_LOW = 2'd2,
        ST_ASSERT  = 2'd3
    } rst_state_e;

    // 500 ms of keyboard clock held low
    localparam int DEF_KBD_HOLD_CYCLES    = 14318180;
    // 100 ms minimum reset drive
    localparam int DEF_RESET_PULSE_CYCLES = 2863636;

endpackage

// File: rtl/amiga_reset_ctl_if.sv
// Board-side signals of the reset controller: keyboard clock, shared _RST sense, drive/status outputs.
// The controller takes the slave view; the board (or bench) takes the master view.
interface amiga_reset_ctl_if;

    logic KCLK;
    logic _RST_SENSE;
    logic RST_DRV;
    logic HLT_DRV;
    logic RESET_ACTIVE;
    logic KBD_RESET_EVT;
    logic CPU_RESET_SEEN;

    modport master (
        output KCLK,
        output _RST_SENSE,
        input  RST_DRV,
        input  HLT_DRV,
        input  RESET_ACTIVE,
        input  KBD_RESET_EVT,
        input  CPU_RESET_SEEN
    );

    modport slave (
        input  KCLK,
        input  _RST_SENSE,
        output RST_DRV,
        output HLT_DRV,
        output RESET_ACTIVE,
        output KBD_RESET_EVT,
        output CPU_RESET_SEEN
    );

endinterface

// File: rtl/amiga_sync2.sv
// Two-flop synchronizer for an asynchronous level; input sampled at edge n is visible after edge n+1.
// Both flops preset to 1 (idle/released level of the lines it serves).
module amiga_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/amiga_reset_ctl.sv
// Amiga reset controller: power-up reset pulse, keyboard long-press reset, external _RST detection.
// Drive outputs decode directly from state; event pulses are registered one-cycle strobes.
module amiga_reset_ctl
    import amiga_reset_pkg::*;
#(
    parameter int KBD_HOLD_CYCLES    = DEF_KBD_HOLD_CYCLES,
    parameter int RESET_PULSE_CYCLES = DEF_RESET_PULSE_CYCLES
) (
    input  logic             CLK,
    input  logic             RST,
    amiga_reset_ctl_if.slave bus
);

    localparam int HW = $clog2(KBD_HOLD_CYCLES + 1);
    localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_TC    = HW'(KBD_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(KBD_HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_TC   = PW'(RESET_PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);

    rst_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic          kbd_evt_q, kbd_evt_d;
    logic          seen_q, seen_d;
    logic          rs_prev_q;

    logic          kclk_s;
    logic          rsense_s;
    logic          drv;
    logic [HW-1:0] hold_inc;
    logic [PW-1:0] pulse_inc;
    logic          pulse_done;

    amiga_sync2 u_sync_kclk (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (bus.KCLK),
        .q_o   (kclk_s)
    );

    amiga_sync2 u_sync_rsense (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (bus._RST_SENSE),
        .q_o   (rsense_s)
    );

    assign hold_inc   = (hold_q == HOLD_TC) ? hold_q : hold_q + 1'b1;
    assign pulse_inc  = (pulse_q == PULSE_TC) ? pulse_q : pulse_q + 1'b1;
    // The edge that would make the count reach its target is the edge that completes it
    assign pulse_done = (pulse_q >= PULSE_LAST);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pulse_d   = pulse_inc;
        kbd_evt_d = 1'b0;

        case (state_q)
            ST_POWERUP: begin
                hold_d = '0;
                if (pulse_done) begin
                    state_d = ST_RUN;
                    pulse_d = '0;
                end
            end

            ST_RUN: begin
                hold_d  = '0;
                pulse_d = '0;
                if (!kclk_s) begin
                    if (KBD_HOLD_CYCLES == 1) begin
                        state_d   = ST_ASSERT;
                        kbd_evt_d = 1'b1;
                    end else begin
                        state_d = ST_KBD_LOW;
                        hold_d  = HW'(1);
                    end
                end
            end

            ST_KBD_LOW: begin
                pulse_d = '0;
                if (kclk_s) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else if (hold_q >= HOLD_LAST) begin
                    state_d   = ST_ASSERT;
                    hold_d    = '0;
                    kbd_evt_d = 1'b1;
                end else begin
                    hold_d = hold_inc;
                end
            end

            ST_ASSERT: begin
                hold_d = '0;
                if (pulse_done && kclk_s) begin
                    state_d = ST_RUN;
                    pulse_d = '0;
                end
            end

            default: begin
                state_d = ST_POWERUP;
                hold_d  = '0;
                pulse_d = '0;
            end
        endcase
    end

    // Only a falling _RST we are not driving ourselves counts as an external reset
    assign seen_d = ((state_q == ST_RUN) || (state_q == ST_KBD_LOW)) && !drv
                    && rs_prev_q && !rsense_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_POWERUP;
            hold_q    <= '0;
            pulse_q   <= '0;
            kbd_evt_q <= 1'b0;
            seen_q    <= 1'b0;
            rs_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pulse_q   <= pulse_d;
            kbd_evt_q <= kbd_evt_d;
            seen_q    <= seen_d;
            rs_prev_q <= rsense_s;
        end
    end

    assign drv = (state_q == ST_POWERUP) || (state_q == ST_ASSERT);

    assign bus.RST_DRV        = drv;
    assign bus.HLT_DRV        = drv;
    assign bus.RESET_ACTIVE   = (state_q != ST_RUN);
    assign bus.KBD_RESET_EVT  = kbd_evt_q;
    assign bus.CPU_RESET_SEEN = seen_q;

endmodule

// File: doc/amiga_reset_ctl.md
AMIGA_RESET_CTL -- requirements
Module: amiga_reset_ctl

Interface
REQ-001 SHALL have parameter KBD_HOLD_CYCLES, default 14318180, meaning consecutive synchronized KCLK-low cycles (500 ms at 28.63636 MHz) that trigger a keyboard reset; legal range >=1.
REQ-002 SHALL have parameter RESET_PULSE_CYCLES, default 2863636, meaning the minimum reset-drive duration (100 ms at 28.63636 MHz); legal range >=1.
REQ-003 SHALL have port CLK, input, 1, the single clock (28.63636 MHz master).
REQ-004 SHALL have port RST, input, 1, reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port KCLK, input, 1, asynchronous keyboard clock line.
REQ-006 SHALL have port _RST_SENSE, input, 1, asynchronous level of the shared open-drain _RST line.
REQ-007 SHALL have port RST_DRV, output, 1, where 1 means pull _RST low.
REQ-008 SHALL have port HLT_DRV, output, 1, where 1 means pull _HLT low.
REQ-009 SHALL have port RESET_ACTIVE, output, 1, high in every state except RUN.
REQ-010 SHALL have port KBD_RESET_EVT, output, 1, a one-cycle pulse on each keyboard-triggered reset.
REQ-011 SHALL have port CPU_RESET_SEEN, output, 1, a one-cycle pulse when _RST is observed low while not driven by this block.

Function
REQ-012 SHALL pass KCLK and _RST_SENSE through separate two-flop synchronizers; a level sampled at edge n appears synchronized after edge n+1.
REQ-013 SHALL implement states POWERUP, RUN, KBD_LOW and ASSERT.
REQ-014 POWERUP SHALL drive RST_DRV=1, count RESET_PULSE_CYCLES cycles, then enter RUN.
REQ-015 RUN SHALL drive RST_DRV=0 and enter KBD_LOW with hold counter=1 on the first synchronized KCLK low.
REQ-016 KBD_LOW SHALL increment the hold counter on each synchronized-low cycle and return to RUN with the counter cleared on any synchronized-high cycle.
REQ-017 KBD_LOW SHALL enter ASSERT on the cycle the hold counter equals KBD_HOLD_CYCLES with KCLK still low, and pulse KBD_RESET_EVT on that transition.
REQ-018 ASSERT SHALL drive RST_DRV=1 for at least RESET_PULSE_CYCLES cycles.
REQ-019 ASSERT SHALL remain while synchronized KCLK is low and exit to RUN on the first cycle where the pulse count is done and KCLK is high.
REQ-020 HLT_DRV SHALL equal RST_DRV in every cycle.
REQ-021 CPU_RESET_SEEN SHALL pulse once on the falling edge of synchronized _RST_SENSE in RUN or KBD_LOW only; this event SHALL cause no state change and SHALL be suppressed whenever RST_DRV=1.
REQ-022 Counters SHALL be sized $clog2(param+1) bits, saturate at their terminal count, and never wrap.
REQ-023 If KCLK is released on hold count KBD_HOLD_CYCLES-1, the block SHALL return to RUN with no reset.
REQ-024 If KCLK is low on POWERUP exit, the block SHALL enter RUN and then start KBD_LOW normally.

Reset
REQ-025 While RST=1, the block SHALL set state POWERUP, clear all counters, set RST_DRV=1 and HLT_DRV=1, set RESET_ACTIVE=1, set KBD_RESET_EVT=0 and CPU_RESET_SEEN=0, and preset synchronizer flops to 1.
REQ-026 RST asserted mid-operation in any state SHALL restart a full POWERUP pulse.

Structure
REQ-027 State encoding and default cycle constants SHALL live in shared package amiga_reset_pkg.
REQ-028 The synchronizer SHALL be sub-module amiga_sync2, instantiated twice.

Verification (KBD_HOLD_CYCLES=8, RESET_PULSE_CYCLES=16)
REQ-029 Release RST -> RST_DRV high for exactly 16 cycles, then 0, with RESET_ACTIVE=0.
REQ-030 Hold KCLK low from first sample edge n -> RST_DRV rises after edge n+9, KBD_RESET_EVT pulses once, and RST_DRV stays high 16 cycles when KCLK is released at n+12.
REQ-031 Hold KCLK low for 7 sampled cycles, then high -> no RST_DRV and no KBD_RESET_EVT.
REQ-032 Hold KCLK low for 40 cycles -> RST_DRV held until 2 cycles after the KCLK high sample, with a single KBD_RESET_EVT.
REQ-033 Pulse _RST_SENSE low for 10 cycles in RUN -> one CPU_RESET_SEEN pulse and no RST_DRV; repeat during ASSERT -> no pulse.
REQ-034 Assert RST during ASSERT at pulse count 5 -> full 16-cycle POWERUP after RST release.
